disp_scan_ctrl: RTL

- Scan controller for the 4-digit multiplexed 7-segment display.
- Holds a double-buffered digit store. Requesters write the shadow bank through a valid/ready handshake, and a commit request swaps it into the active bank at the next frame boundary.
- Scans the digits with a programmable dwell time and a blanking gap between digits, so segments never ghost.
- Sits between the value-formatting logic and the display pins. It replaces free-running scanning with a sequenced, tear-free scan.

---
 rtl/disp_pkg.sv | 30 +++
 rtl/disp_pwm_gen.sv | 38 +++
 rtl/disp_scan_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// ============================================================================
// Module      : disp_pkg
// Description : Shared types, default timing constants and a width helper
//               for the multiplexed display scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } disp_state_t;

    localparam int c_DEFAULT_DWELL = 100000;
    localparam int c_DEFAULT_BLANK = 16;

    // Number of bits needed to encode values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/disp_pwm_gen.sv
// ============================================================================
// Module      : disp_pwm_gen
// Description : Brightness gate for the lit phase. Level is latched at each
//               frame start; 15 is full on, 0 is dark.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_pwm_gen (
    input  logic       clock,
    input  logic       reset,
    input  logic       show_nxt,
    input  logic       frame_start,
    input  logic [3:0] brightness,
    output logic       gate
);

    logic [3:0] r_level;
    logic [3:0] r_pwm_cnt;
    logic [3:0] w_level;

    // The level sampled on a frame-start edge already governs that edge.
    assign w_level = frame_start ? brightness : r_level;
    assign gate    = (w_level == 4'hF) || (r_pwm_cnt < w_level);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_level   <= 4'h0;
            r_pwm_cnt <= 4'h0;
        end else begin
            if (frame_start) r_level <= brightness;
            if (show_nxt)    r_pwm_cnt <= r_pwm_cnt + 4'h1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
// ============================================================================
// Module      : disp_scan_ctrl
// Description : Tear-free multiplexed 7-segment scan controller with a
//               double-buffered digit store and blanking between digits.
//               Optional brightness PWM when DISP_SCAN_PWM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int SEG_W  = 8,
    parameter int DWELL  = c_DEFAULT_DWELL,
    parameter int BLANK  = c_DEFAULT_BLANK
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [1:0]        wr_idx,
    input  logic [SEG_W-1:0]  wr_data,
    input  logic              commit,
    output logic              commit_done,
    output logic              frame_tick,
`ifdef DISP_SCAN_PWM_EN
    input  logic [3:0]        brightness,
`endif
    output logic [SEG_W-1:0]  dig_val,
    output logic [DIGITS-1:0] dig_sel
);

    localparam int c_CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int c_CNT_W   = (clog2(c_CNT_MAX + 1) < 1) ? 1 : clog2(c_CNT_MAX + 1);
    localparam int c_DIG_W   = (DIGITS > 1) ? clog2(DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_DIG_W-1:0] c_DIG_LAST   = c_DIG_W'(DIGITS - 1);
    localparam logic [c_DIG_W-1:0] c_DIG_ONE    = c_DIG_W'(1);
    localparam logic [DIGITS-1:0]  c_SEL_ONE    = DIGITS'(1);

    disp_state_t        r_state;
    disp_state_t        w_nxt_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_nxt_cnt;
    logic [c_DIG_W-1:0] r_digit;
    logic [c_DIG_W-1:0] w_nxt_digit;
    logic [SEG_W-1:0]   r_shadow [DIGITS];
    logic [SEG_W-1:0]   r_active [DIGITS];
    logic               r_pending;
    logic               w_boundary;
    logic               w_swap;
    logic               w_write;
    logic               w_show;
    logic               w_pwm_gate;
    logic [SEG_W-1:0]   w_show_val;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_digit = r_digit;
        w_boundary  = 1'b0;
        if (!enable) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_digit = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state = (BLANK > 0) ? ST_BLANK : ST_SHOW;
                    w_nxt_cnt   = '0;
                    w_nxt_digit = '0;
                    w_boundary  = 1'b1;
                end
                ST_BLANK: begin
                    if (r_cnt == c_BLANK_LAST) begin
                        w_nxt_state = ST_SHOW;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_cnt = r_cnt + c_CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == c_DWELL_LAST) begin
                        w_nxt_state = (BLANK > 0) ? ST_BLANK : ST_SHOW;
                        w_nxt_cnt   = '0;
                        if (r_digit == c_DIG_LAST) begin
                            w_nxt_digit = '0;
                            w_boundary  = 1'b1;
                        end else begin
                            w_nxt_digit = r_digit + c_DIG_ONE;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                    w_nxt_digit = '0;
                end
            endcase
        end
    end

    // A pending swap also drains while parked in IDLE so commits never stall.
    assign w_swap   = r_pending && (w_boundary || (r_state == ST_IDLE));
    assign wr_ready = ~r_pending;
    assign w_write  = wr_valid && wr_ready && (int'(wr_idx) < DIGITS);
    assign w_show   = (w_nxt_state == ST_SHOW);

    // Digit 0 shown on the swap edge must already carry the new bank.
    assign w_show_val = w_swap ? r_shadow[w_nxt_digit] : r_active[w_nxt_digit];

`ifdef DISP_SCAN_PWM_EN
    disp_pwm_gen u_pwm (
        .clock       (clock),
        .reset       (reset),
        .show_nxt    (w_show),
        .frame_start (w_boundary),
        .brightness  (brightness),
        .gate        (w_pwm_gate)
    );
`else
    assign w_pwm_gate = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_digit     <= '0;
            r_pending   <= 1'b0;
            frame_tick  <= 1'b0;
            commit_done <= 1'b0;
            dig_sel     <= '0;
            dig_val     <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_digit     <= w_nxt_digit;
            frame_tick  <= w_boundary;
            commit_done <= w_swap;
            if (w_write) r_shadow[wr_idx] <= wr_data;
            if (w_swap) begin
                for (int i = 0; i < DIGITS; i++) r_active[i] <= r_shadow[i];
            end
            if (r_pending) begin
                if (w_swap) r_pending <= 1'b0;
            end else if (commit) begin
                r_pending <= 1'b1;
            end
            dig_sel <= (w_show && w_pwm_gate) ? (c_SEL_ONE << w_nxt_digit) : '0;
            dig_val <= w_show ? w_show_val : '0;
        end
    end

endmodule

`default_nettype wire
